// File: rtl/music_pkg.sv
// Note codes and tone half-period table for the note playback datapath.
// Half-periods are cycles of a 50 MHz clock, round(25e6 / f).
package music_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_CS4  = 4'd2;
    localparam logic [3:0] NOTE_D4   = 4'd3;
    localparam logic [3:0] NOTE_DS4  = 4'd4;
    localparam logic [3:0] NOTE_E4   = 4'd5;
    localparam logic [3:0] NOTE_F4   = 4'd6;
    localparam logic [3:0] NOTE_FS4  = 4'd7;
    localparam logic [3:0] NOTE_G4   = 4'd8;
    localparam logic [3:0] NOTE_GS4  = 4'd9;
    localparam logic [3:0] NOTE_A4   = 4'd10;
    localparam logic [3:0] NOTE_AS4  = 4'd11;
    localparam logic [3:0] NOTE_B4   = 4'd12;

    localparam int HP_W = 17;

    localparam logic [HP_W-1:0] HALF_PERIOD_TABLE [12] = '{
        17'd95556, 17'd90193, 17'd85131, 17'd80353,
        17'd75843, 17'd71586, 17'd67569, 17'd63776,
        17'd60197, 17'd56818, 17'd53629, 17'd50619
    };

    // Codes 0 and 13..15 are rests and map to a zero half-period.
    function automatic logic [HP_W-1:0] half_period(input logic [3:0] code);
        logic [HP_W-1:0] hp;
        hp = '0;
        if (code >= NOTE_C4 && code <= NOTE_B4) begin
            hp = HALF_PERIOD_TABLE[code - NOTE_C4];
        end
        return hp;
    endfunction

endpackage

// File: rtl/note_playback_datapath_tone_gen.sv
// Square-wave generator: down-counter reloading from the half-period, toggling
// the output at terminal count. A zero half-period or enable=0 means silence.
module tone_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [16:0] half_period,
    output logic        tone
);

    logic [16:0] count;
    logic [16:0] hp_q;

    // hp_q remembers the half-period in use so a changed note restarts the
    // phase while a repeated note keeps running; silence clears it so the
    // next note always loads fresh.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            hp_q  <= '0;
            tone  <= 1'b0;
        end else if (!enable || half_period == '0) begin
            count <= '0;
            hp_q  <= '0;
            tone  <= 1'b0;
        end else if (half_period != hp_q) begin
            count <= half_period;
            hp_q  <= half_period;
            tone  <= 1'b0;
        end else if (count == '0) begin
            count <= hp_q;
            tone  <= ~tone;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/note_playback_datapath.sv
// Note recorder/player: edge-triggered writes into a small note memory,
// registered playback of the indexed slot, and a square-wave tone output.
module note_playback_datapath
    import music_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int SIM_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_note,
    input  logic                       ld_play,
    input  logic [$clog2(DEPTH)-1:0]   note_counter,
    input  logic [3:0]                 note_in,
    output logic                       tone_out,
    output logic [3:0]                 cur_note,
    output logic                       playing,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic                       mem_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

    logic [3:0]      mem [DEPTH];
    logic            ld_note_q;
    logic            ld_rise;
    logic [HP_W-1:0] tone_hp;

    assign ld_rise = ld_note & ~ld_note_q;

    // A record edge wins over playback: cur_note holds while the write lands.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOTE_REST;
            end
            wr_ptr    <= '0;
            mem_full  <= 1'b0;
            ld_note_q <= 1'b0;
            cur_note  <= NOTE_REST;
            playing   <= 1'b0;
        end else begin
            ld_note_q <= ld_note;
            playing   <= ld_play;
            if (ld_rise) begin
                mem[wr_ptr] <= note_in;
                if (wr_ptr == LAST_SLOT) begin
                    mem_full <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (!ld_play) begin
                cur_note <= NOTE_REST;
            end else if (!ld_rise) begin
                cur_note <= mem[note_counter];
            end
        end
    end

    assign tone_hp = half_period(cur_note) >> SIM_SHIFT;

    tone_gen u_tone_gen (
        .clk         (clk),
        .reset       (reset),
        .enable      (playing),
        .half_period (tone_hp),
        .tone        (tone_out)
    );

endmodule

// File: tb/tb_note_playback_datapath.sv
// Directed bench for note_playback_datapath with SIM_SHIFT=10.
module tb_note_playback_datapath;

    logic       clk;
    logic       reset;
    logic       ld_note;
    logic       ld_play;
    logic [3:0] note_counter;
    logic [3:0] note_in;
    logic       tone_out;
    logic [3:0] cur_note;
    logic       playing;
    logic [3:0] wr_ptr;
    logic       mem_full;

    int checks   = 0;
    int failures = 0;

    note_playback_datapath #(.DEPTH(16), .SIM_SHIFT(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_note      (ld_note),
        .ld_play      (ld_play),
        .note_counter (note_counter),
        .note_in      (note_in),
        .tone_out     (tone_out),
        .cur_note     (cur_note),
        .playing      (playing),
        .wr_ptr       (wr_ptr),
        .mem_full     (mem_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input logic [3:0] n);
        note_in = n;
        ld_note = 1'b1;
        repeat (5) step();
        ld_note = 1'b0;
        repeat (2) step();
    endtask

    task automatic play(input logic [3:0] slot);
        ld_play      = 1'b1;
        note_counter = slot;
        step();
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (tone_out) hi++;
        end
    endtask

    // Cycles between two consecutive rising edges of tone_out; 0 on timeout.
    task automatic measure_period(output int period);
        logic prev;
        bit   found;
        period = 0;
        prev   = tone_out;
        found  = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            step();
            if (tone_out && !prev) found = 1'b1;
            prev = tone_out;
        end
        if (found) begin
            found = 1'b0;
            for (int k = 1; k <= 600 && !found; k++) begin
                step();
                if (tone_out && !prev) begin
                    found  = 1'b1;
                    period = k;
                end
                prev = tone_out;
            end
        end
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = tone_out;
        for (int k = 0; k < 600 && !ok; k++) begin
            step();
            if (tone_out && !prev) ok = 1'b1;
            prev = tone_out;
        end
    endtask

    initial begin
        int  period;
        int  hi;
        bit  ok;

        reset        = 1'b0;
        ld_note      = 1'b0;
        ld_play      = 1'b0;
        note_counter = 4'd0;
        note_in      = 4'd0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("rst_tone", tone_out, 0);
        check("rst_cur_note", cur_note, 0);
        check("rst_playing", playing, 0);
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_mem_full", mem_full, 0);

        play(4'd5);
        check("empty_cur_note", cur_note, 0);
        check("empty_playing", playing, 1);
        count_high(100, hi);
        check("empty_silent", hi, 0);
        ld_play = 1'b0;
        step();

        record(4'd1);
        check("held_one_write", wr_ptr, 1);
        record(4'd10);
        record(4'd0);
        record(4'd12);
        check("rec4_wr_ptr", wr_ptr, 4);
        check("rec4_mem_full", mem_full, 0);

        play(4'd0);
        check("slot0", cur_note, 1);
        play(4'd1);
        check("slot1", cur_note, 10);
        measure_period(period);
        check("period_a4", period, 112);
        play(4'd2);
        check("slot2_rest", cur_note, 0);
        step();
        check("rest_tone_low", tone_out, 0);
        play(4'd3);
        check("slot3", cur_note, 12);
        measure_period(period);
        check("period_b4", period, 100);

        wait_rise(ok);
        check("midtone_rise_seen", ok, 1);
        reset   = 1'b0;
        ld_play = 1'b0;
        step();
        check("midrst_tone", tone_out, 0);
        check("midrst_cur_note", cur_note, 0);
        check("midrst_playing", playing, 0);
        check("midrst_wr_ptr", wr_ptr, 0);
        reset = 1'b1;
        step();
        play(4'd3);
        check("mem_cleared", cur_note, 0);
        ld_play = 1'b0;
        step();

        for (int i = 1; i <= 15; i++) begin
            record(4'(i));
        end
        check("w15_wr_ptr", wr_ptr, 15);
        check("w15_mem_full", mem_full, 0);
        record(4'd9);
        check("w16_wr_ptr", wr_ptr, 15);
        check("w16_mem_full", mem_full, 1);
        record(4'd9);
        check("w17_wr_ptr", wr_ptr, 15);
        play(4'd15);
        check("slot15_nine", cur_note, 9);
        play(4'd14);
        check("slot14", cur_note, 15);
        play(4'd12);
        check("slot12_code13", cur_note, 13);
        count_high(60, hi);
        check("code13_silent", hi, 0);
        ld_play = 1'b0;
        step();
        record(4'd1);
        check("rewrite_mem_full", mem_full, 1);

        // Slot 15 and slot 0 both hold C4: the wrap must not restart the phase.
        play(4'd15);
        check("slot15_rewritten", cur_note, 1);
        wait_rise(ok);
        check("wrap_rise_seen", ok, 1);
        hi = 1;
        for (int k = 0; k < 400; k++) begin
            if (hi == 30) note_counter = 4'd0;
            step();
            if (!tone_out) break;
            hi++;
        end
        check("wrap_high_len", hi, 94);
        check("wrap_cur_note", cur_note, 1);

        note_counter = 4'd3;
        note_in      = 4'd5;
        ld_note      = 1'b1;
        step();
        check("prio_hold", cur_note, 1);
        step();
        check("prio_after", cur_note, 4);
        ld_note      = 1'b0;
        note_counter = 4'd15;
        step();
        check("prio_written", cur_note, 5);
        ld_play = 1'b0;
        step();
        check("stop_cur_note", cur_note, 0);
        check("stop_playing", playing, 0);
        step();
        check("stop_tone", tone_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_playback_datapath.md
NOTE_PLAYBACK_DATAPATH -- requirements
Module: note_playback_datapath

Interface
REQ-001 Parameter: DEPTH, 16, number of note slots (power of two; address width 4).
REQ-002 Parameter: SIM_SHIFT, 0, right-shift applied to every half-period constant (simulation speed-up only).
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 ld_note  input  1  controller record strobe; level, may stay high for many cycles.
REQ-006 ld_play  input  1  controller playback-active level.
REQ-007 note_counter  input  4  playback slot index from controller.
REQ-008 note_in  input  4  note code from switches: 0 = rest, 1..12 = C4..B4 chromatic, 13..15 = rest.
REQ-009 tone_out  output  1  square-wave audio to codec/buzzer.
REQ-010 cur_note  output  4  note code currently sounding.
REQ-011 playing  output  1  high while a playback note is active.
REQ-012 wr_ptr  output  4  next slot to be written.
REQ-013 mem_full  output  1  high once slot 15 is written.

Function
REQ-014 Storage SHALL be a 16 x 4-bit register array; every slot SHALL reset to 0 (rest).
REQ-015 Rising edge of ld_note: ld_note=1 this cycle, registered ld_note_q=0. Each edge SHALL write note_in to mem[wr_ptr] on that clock edge.
REQ-016 wr_ptr SHALL increment after each write; at 15 the write SHALL occur, wr_ptr SHALL hold at 15, and mem_full SHALL set. Later edges SHALL rewrite slot 15.
REQ-017 ld_note held high SHALL produce exactly one write.
REQ-018 If ld_play=1 and ld_note is not in a rising-edge cycle, cur_note SHALL register mem[note_counter] on the next edge. Latency: 1 cycle.
REQ-019 playing SHALL be the 1-cycle-registered ld_play. If ld_play=0, cur_note SHALL clear to 0 on the next edge.
REQ-020 A ld_note rising edge in the same cycle as ld_play=1 SHALL take priority: the write occurs and cur_note holds its value for that cycle.
REQ-021 Tone generator: 17-bit down-counter. When cur_note changes, it SHALL load half_period(cur_note)>>SIM_SHIFT and tone_out SHALL go 0.
REQ-022 Counter at 0: tone_out SHALL toggle and the counter SHALL reload. Output period = 2 x (half_period+1) cycles.
REQ-023 For rest codes (0, 13..15) or playing=0: tone_out SHALL be 0 and the counter SHALL hold at 0.
REQ-024 Half-periods at 50 MHz, round(25e6/f): C4=95556, C#4=90193, D4=85131, D#4=80353, E4=75843, F4=71586, F#4=67569, G4=63776, G#4=60197, A4=56818, A#4=53629, B4=50619.
REQ-025 The same code on consecutive slots SHALL NOT restart the phase. The counter SHALL keep running, with no click.
REQ-026 note_counter wrap 15->0 SHALL be treated as an ordinary index change.

Reset
REQ-027 With reset=0 at a clk edge, the following SHALL clear to 0: memory, wr_ptr, mem_full, cur_note, playing, tone_out, tone counter, ld_note_q.
REQ-028 Reset asserted mid-playback or mid-write SHALL abort the operation. No partial write SHALL remain.
REQ-029 After reset releases, the first ld_note edge SHALL write slot 0.

Structure
REQ-030 Package music_pkg SHALL hold: note-code localparams (NOTE_REST, NOTE_C4..NOTE_B4), the 12-entry half-period table, and a function half_period(code) that returns 0 for rest codes.
REQ-031 The tone generator SHALL be one sub-module, tone_gen (inputs clk, reset, enable, half_period[16:0]; output tone). Storage and write logic SHALL stay in the top level.

Verification (SIM_SHIFT=10 unless stated)
REQ-032 Reset -> all outputs 0. Play any slot -> tone_out stays 0.
REQ-033 Record with one ld_note pulse (held 5 cycles) per value: 1, 10, 0, 12 -> mem[0..3] = 1,10,0,12; wr_ptr=4; mem_full=0.
REQ-034 ld_play=1, note_counter=1 -> cur_note=10 one cycle later. tone_out period = 2 x ((56818>>10)+1) = 112 cycles.
REQ-035 note_counter=2 (rest) -> tone_out=0 within 1 cycle of the cur_note update. note_counter=3 -> period 2 x ((50619>>10)+1) = 100 cycles.
REQ-036 Write 17 notes: 1..15, 9, 9 -> mem_full=1 after the 16th; wr_ptr=15; slot 15 = 9 after the 17th.
REQ-037 ld_note edge coincident with ld_play=1 -> write occurs and cur_note unchanged that cycle. Reset pulse mid-tone -> tone_out=0 on the next edge.
